// File: rtl/skinny_inv_core.sv
// Iterative SKINNY-128-384 decryption core.
// Takes a ciphertext and the round-0 tweakey (TK1/TK2/TK3), runs the tweakey
// schedule forward to its final value, then removes one round per clock,
// last round first. Used for decryption-side and verification paths.
//
// state | meaning
// IDLE  | ready for a block, di_ready=1
// KFWD  | fast-forwarding the tweakey schedule, ROUNDS cycles
// DEC   | one inverse round per cycle, ROUNDS cycles
// DONE  | pt valid, waiting for do_ready
module skinny_inv_core #(
  parameter int ROUNDS = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         di_valid,
  output logic         di_ready,
  input  logic [127:0] ct,
  input  logic [127:0] cnt,
  input  logic [127:0] tweak,
  input  logic [127:0] key,
  output logic         do_valid,
  input  logic         do_ready,
  output logic [127:0] pt
);

  typedef enum logic [1:0] {IDLE, KFWD, DEC, DONE} state_t;

  localparam logic [5:0] RLAST = 6'(ROUNDS - 1);

  // Tweakey cell permutation: new[i] = old[TK_P[i]]; TK_PI is its inverse.
  localparam int TK_P  [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
  localparam int TK_PI [16] = '{8, 9, 10, 11, 12, 13, 14, 15, 2, 0, 4, 7, 6, 3, 5, 1};

  state_t       st_q;
  logic [127:0] s_q;
  logic [127:0] tk1_q, tk2_q, tk3_q;
  logic [5:0]   rc_q;
  logic [5:0]   rcnt_q;
  logic [127:0] pt_q;
  logic         do_valid_q;
  logic         di_ready_q;

  logic [127:0] tk1_fwd_d, tk2_fwd_d, tk3_fwd_d;
  logic [127:0] tk1_bwd_d, tk2_bwd_d, tk3_bwd_d;
  logic [5:0]   rc_fwd_d, rc_bwd_d;
  logic [127:0] s_dec_d;

  // The S-box is built from a NOR-XOR layer (an involution), a bit permutation
  // and a final bit swap; inverting it means running those pieces backwards.
  function automatic logic [7:0] sb_mix(input logic [7:0] x);
    return {x[7:5], x[4] ^ ~(x[7] | x[6]), x[3:1], x[0] ^ ~(x[3] | x[2])};
  endfunction

  function automatic logic [7:0] sb_iperm(input logic [7:0] y);
    return {y[5], y[4], y[0], y[3], y[1], y[7], y[6], y[2]};
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] y);
    logic [7:0] x;
    x = sb_mix({y[7:3], y[1], y[2], y[0]});
    x = sb_mix(sb_iperm(x));
    x = sb_mix(sb_iperm(x));
    x = sb_mix(sb_iperm(x));
    return x;
  endfunction

  function automatic logic [127:0] tk_perm(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = v[127-8*TK_P[i] -: 8];
    return r;
  endfunction

  function automatic logic [127:0] tk_iperm(input logic [127:0] v);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = v[127-8*TK_PI[i] -: 8];
    return r;
  endfunction

  // TK2 forward LFSR on rows 0-1; the inverse variant undoes it.
  function automatic logic [127:0] lfsr2(input logic [127:0] v, input logic inv);
    logic [127:0] r;
    logic [7:0]   x;
    r = v;
    for (int i = 0; i < 8; i++) begin
      x = v[127-8*i -: 8];
      r[127-8*i -: 8] = inv ? {x[0] ^ x[6], x[7:1]} : {x[6:0], x[7] ^ x[5]};
    end
    return r;
  endfunction

  // TK3 forward LFSR on rows 0-1; it is the TK2 inverse and vice versa.
  function automatic logic [127:0] lfsr3(input logic [127:0] v, input logic inv);
    logic [127:0] r;
    logic [7:0]   x;
    r = v;
    for (int i = 0; i < 8; i++) begin
      x = v[127-8*i -: 8];
      r[127-8*i -: 8] = inv ? {x[6:0], x[7] ^ x[5]} : {x[0] ^ x[6], x[7:1]};
    end
    return r;
  endfunction

  // One inverse round. tkx is TK1^TK2^TK3 of the round being removed, rc the
  // constant that round used when encrypting.
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] tkx,
                                             input logic [5:0]   rc);
    logic [31:0]  r0, r1, r2, r3;
    logic [31:0]  m0, m1, m2, m3;
    logic [127:0] sr, rk, r;
    {r0, r1, r2, r3} = s;
    m0 = r1;
    m1 = r1 ^ r2 ^ r3;
    m2 = r1 ^ r3;
    m3 = r0 ^ r3;
    sr = {m0, m1[23:0], m1[31:24], m2[15:0], m2[31:16], m3[7:0], m3[31:8]};
    rk = {tkx[127:64], 64'h0};
    rk[123:120] = rk[123:120] ^ rc[3:0];
    rk[89:88]   = rk[89:88] ^ rc[5:4];
    rk[57]      = rk[57] ^ 1'b1;
    sr = sr ^ rk;
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_inv(sr[127-8*i -: 8]);
    return r;
  endfunction

  // Forward and backward tweakey/rc steps plus the inverse round datapath.
  always_comb begin
    tk1_fwd_d = tk_perm(tk1_q);
    tk2_fwd_d = lfsr2(tk_perm(tk2_q), 1'b0);
    tk3_fwd_d = lfsr3(tk_perm(tk3_q), 1'b0);
    tk1_bwd_d = tk_iperm(tk1_q);
    tk2_bwd_d = tk_iperm(lfsr2(tk2_q, 1'b1));
    tk3_bwd_d = tk_iperm(lfsr3(tk3_q, 1'b1));
    rc_fwd_d  = {rc_q[4:0], rc_q[5] ^ rc_q[4] ^ 1'b1};
    rc_bwd_d  = {rc_q[0] ^ rc_q[5] ^ 1'b1, rc_q[5:1]};
    s_dec_d   = inv_round(s_q, tk1_bwd_d ^ tk2_bwd_d ^ tk3_bwd_d, rc_q);
  end

  // Control FSM with all datapath and output registers; rst wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      s_q        <= '0;
      tk1_q      <= '0;
      tk2_q      <= '0;
      tk3_q      <= '0;
      rc_q       <= '0;
      rcnt_q     <= '0;
      pt_q       <= '0;
      do_valid_q <= 1'b0;
      di_ready_q <= 1'b1;
    end else begin
      case (st_q)
        IDLE: begin
          if (di_valid && di_ready_q) begin
            s_q        <= ct;
            tk1_q      <= cnt;
            tk2_q      <= tweak;
            tk3_q      <= key;
            rc_q       <= '0;
            rcnt_q     <= '0;
            di_ready_q <= 1'b0;
            st_q       <= KFWD;
          end
        end
        KFWD: begin
          tk1_q <= tk1_fwd_d;
          tk2_q <= tk2_fwd_d;
          tk3_q <= tk3_fwd_d;
          rc_q  <= rc_fwd_d;
          if (rcnt_q == RLAST) begin
            rcnt_q <= RLAST;
            st_q   <= DEC;
          end else begin
            rcnt_q <= rcnt_q + 6'd1;
          end
        end
        DEC: begin
          s_q   <= s_dec_d;
          tk1_q <= tk1_bwd_d;
          tk2_q <= tk2_bwd_d;
          tk3_q <= tk3_bwd_d;
          rc_q  <= rc_bwd_d;
          if (rcnt_q == 6'd0) begin
            pt_q       <= s_dec_d;
            do_valid_q <= 1'b1;
            st_q       <= DONE;
          end else begin
            rcnt_q <= rcnt_q - 6'd1;
          end
        end
        DONE: begin
          if (do_ready) begin
            do_valid_q <= 1'b0;
            di_ready_q <= 1'b1;
            st_q       <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign di_ready = di_ready_q;
  assign do_valid = do_valid_q;
  assign pt       = pt_q;

endmodule

// File: tb/tb_skinny_inv_core.sv
// Self-checking bench for skinny_inv_core: a byte-array SKINNY model (forward
// encryption plus a decryption built from the forward rules), a scoreboard
// compare process on the ROUNDS=40 core, and directed runs on 56- and 2-round cores.
module tb_skinny_inv_core;

  localparam int R = 40;

  localparam logic [127:0] P_TK1 = 128'hdf889548cfc7ea52d296339301797449;
  localparam logic [127:0] P_TK2 = 128'hab588a34a47f1ab2dfe9c8293fbea9a5;
  localparam logic [127:0] P_TK3 = 128'hab1afac2611012cd8cef952618c3ebe8;
  localparam logic [127:0] P_PT  = 128'ha3994b66ad85a3459f44e92b08f550cb;
  localparam logic [127:0] P_CT  = 128'h94ecf589e2017c601b38c6346a10dcfa;

  localparam int SRP [16] = '{0, 1, 2, 3, 7, 4, 5, 6, 10, 11, 8, 9, 13, 14, 15, 12};
  localparam int TKP [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, di_valid, di_ready, do_valid, do_ready;
  logic [127:0] ct, cnt, tweak, key, pt;
  logic         rst56, di_valid56, di_ready56, do_valid56, do_ready56;
  logic [127:0] ct56, cnt56, tweak56, key56, pt56;
  logic         rst2, di_valid2, di_ready2, do_valid2, do_ready2;
  logic [127:0] ct2, cnt2, tweak2, key2, pt2;

  skinny_inv_core #(.ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .di_valid(di_valid), .di_ready(di_ready),
    .ct(ct), .cnt(cnt), .tweak(tweak), .key(key),
    .do_valid(do_valid), .do_ready(do_ready), .pt(pt));

  skinny_inv_core #(.ROUNDS(56)) dut56 (
    .clk(clk), .rst(rst56), .di_valid(di_valid56), .di_ready(di_ready56),
    .ct(ct56), .cnt(cnt56), .tweak(tweak56), .key(key56),
    .do_valid(do_valid56), .do_ready(do_ready56), .pt(pt56));

  skinny_inv_core #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst2), .di_valid(di_valid2), .di_ready(di_ready2),
    .ct(ct2), .cnt(cnt2), .tweak(tweak2), .key(key2),
    .do_valid(do_valid2), .do_ready(do_ready2), .pt(pt2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] sinv [256];

  function automatic logic [7:0] s8(input logic [7:0] xi);
    logic [7:0] x;
    x = xi;
    for (int k = 0; k < 4; k++) begin
      x = x ^ ((~(((x >> 1) | x) >> 2)) & 8'h11);
      if (k < 3)
        x = ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
            ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    end
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  function automatic logic [127:0] tk_step(input logic [127:0] v, input int which);
    logic [7:0]   a [16];
    logic [7:0]   x;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = v[127-8*TKP[i] -: 8];
    for (int i = 0; i < 8; i++) begin
      x = a[i];
      if (which == 2) a[i] = {x[6:0], x[7] ^ x[5]};
      else if (which == 3) a[i] = {x[0] ^ x[6], x[7:1]};
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
    return r;
  endfunction

  function automatic logic [127:0] m_enc(input logic [127:0] p, input logic [127:0] k1i,
                                         input logic [127:0] k2i, input logic [127:0] k3i, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [5:0]   rc;
    logic [127:0] k1, k2, k3, ks, r;
    k1 = k1i; k2 = k2i; k3 = k3i; rc = '0;
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8];
    for (int rn = 0; rn < nr; rn++) begin
      rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
      ks = k1 ^ k2 ^ k3;
      for (int i = 0; i < 16; i++) s[i] = s8(s[i]);
      s[0] = s[0] ^ {4'h0, rc[3:0]};
      s[4] = s[4] ^ {6'h0, rc[5:4]};
      s[8] = s[8] ^ 8'h02;
      for (int i = 0; i < 8; i++) s[i] = s[i] ^ ks[127-8*i -: 8];
      for (int i = 0; i < 16; i++) t[i] = s[SRP[i]];
      for (int c = 0; c < 4; c++) begin
        s[c]    = t[c] ^ t[8+c] ^ t[12+c];
        s[4+c]  = t[c];
        s[8+c]  = t[4+c] ^ t[8+c];
        s[12+c] = t[c] ^ t[8+c];
      end
      k1 = tk_step(k1, 1); k2 = tk_step(k2, 2); k3 = tk_step(k3, 3);
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // Decryption: record the forward schedule, then undo each round step by
  // solving the forward equations for their inputs.
  function automatic logic [127:0] m_dec(input logic [127:0] cx, input logic [127:0] k1i,
                                         input logic [127:0] k2i, input logic [127:0] k3i, input int nr);
    logic [127:0] rks [64];
    logic [5:0]   rcs [64];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a, b, c2, d;
    logic [5:0]   rc;
    logic [127:0] k1, k2, k3, r;
    k1 = k1i; k2 = k2i; k3 = k3i; rc = '0;
    for (int rn = 0; rn < nr; rn++) begin
      rc = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
      rcs[rn] = rc;
      rks[rn] = k1 ^ k2 ^ k3;
      k1 = tk_step(k1, 1); k2 = tk_step(k2, 2); k3 = tk_step(k3, 3);
    end
    for (int i = 0; i < 16; i++) s[i] = cx[127-8*i -: 8];
    for (int rn = nr - 1; rn >= 0; rn--) begin
      for (int c = 0; c < 4; c++) begin
        a  = s[4+c];
        c2 = s[12+c] ^ a;
        b  = s[8+c] ^ c2;
        d  = s[c] ^ a ^ c2;
        t[c] = a; t[4+c] = b; t[8+c] = c2; t[12+c] = d;
      end
      for (int i = 0; i < 16; i++) s[SRP[i]] = t[i];
      for (int i = 0; i < 8; i++) s[i] = s[i] ^ rks[rn][127-8*i -: 8];
      s[0] = s[0] ^ {4'h0, rcs[rn][3:0]};
      s[4] = s[4] ^ {6'h0, rcs[rn][5:4]};
      s[8] = s[8] ^ 8'h02;
      for (int i = 0; i < 16; i++) s[i] = sinv[s[i]];
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // ---------------- scoreboard for the ROUNDS=40 core ----------------
  typedef struct packed {
    logic [127:0] c, k1, k2, k3, p;
  } blk_t;

  blk_t sb_q[$];
  blk_t nb;
  bit   chk_en = 0;
  int   due = 0;

  // Compare every cycle on the falling edge: ready/valid timing, pt value and a round trip.
  always @(negedge clk) begin
    if (chk_en) begin
      chk_b("di_ready", di_ready, sb_q.size() == 0);
      chk_b("do_valid", do_valid, (sb_q.size() != 0) && (cyc >= due));
      if (do_valid && sb_q.size() != 0) begin
        chk("pt", pt, sb_q[0].p);
        if (do_ready && !rst) begin
          chk("roundtrip", m_enc(pt, sb_q[0].k1, sb_q[0].k2, sb_q[0].k3, R), sb_q[0].c);
          void'(sb_q.pop_front());
        end
      end
      if (rst) sb_q.delete();
      else if (di_valid && di_ready) begin
        nb.c = ct; nb.k1 = cnt; nb.k2 = tweak; nb.k3 = key;
        nb.p = m_dec(ct, cnt, tweak, key, R);
        sb_q.push_back(nb);
        due = cyc + 1 + 2 * R;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] c, input logic [127:0] k1, input logic [127:0] k2,
                      input logic [127:0] k3, output int acc);
    int n;
    n = 0;
    ct = c; cnt = k1; tweak = k2; key = k3; di_valid = 1'b1;
    while (!di_ready && n < 1000) begin tick(); n++; end
    if (!di_ready) chk_b("send_timeout", di_ready, 1'b1);
    tick();
    acc = cyc;
    di_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !di_ready) && n < 2000) begin tick(); n++; end
    chk_b(name, (sb_q.size() == 0) && di_ready, 1'b1);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] dir_v [4][4];
  bit           seen [256];

  initial begin
    int n, acc0, acc1, acc2, distinct;
    logic [127:0] hold;

    rst = 1; rst56 = 1; rst2 = 1;
    di_valid = 0; di_valid56 = 0; di_valid2 = 0;
    do_ready = 1; do_ready56 = 1; do_ready2 = 1;
    ct = '0; cnt = '0; tweak = '0; key = '0;
    ct56 = '0; cnt56 = '0; tweak56 = '0; key56 = '0;
    ct2 = '0; cnt2 = '0; tweak2 = '0; key2 = '0;

    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (int i = 0; i < 256; i++) begin
      sinv[s8(8'(i))] = 8'(i);
      seen[s8(8'(i))] = 1;
    end

    repeat (3) tick();
    rst = 0; rst56 = 0; rst2 = 0;

    // reset state
    chk_b("rst_di_ready", di_ready, 1'b1);
    chk_b("rst_do_valid", do_valid, 1'b0);
    chk("rst_pt", pt, 128'h0);
    chk_b("rst_di_ready56", di_ready56, 1'b1);
    chk_b("rst_do_valid56", do_valid56, 1'b0);
    chk("rst_pt2", pt2, 128'h0);

    // literal pins for the model
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    chk("sbox_bijective", 128'(distinct), 128'd256);
    chk("s8_00", 128'(s8(8'h00)), 128'h65);
    chk("s8_01", 128'(s8(8'h01)), 128'h4c);
    chk("s8_ff", 128'(s8(8'hff)), 128'hff);
    chk("sinv_65", 128'(sinv[8'h65]), 128'h00);
    chk("model_enc_paper", m_enc(P_PT, P_TK1, P_TK2, P_TK3, 56), P_CT);
    chk("model_dec_paper", m_dec(P_CT, P_TK1, P_TK2, P_TK3, 56), P_PT);

    chk_en = 1;

    // paper vector on the 56-round core, latency 2*56
    ct56 = P_CT; cnt56 = P_TK1; tweak56 = P_TK2; key56 = P_TK3; di_valid56 = 1;
    tick();
    di_valid56 = 0;
    n = 0;
    while (!do_valid56 && n < 300) begin tick(); n++; end
    chk("paper_latency", 128'(n), 128'd112);
    chk("paper_pt", pt56, P_PT);

    // all-zero block on the 2-round core
    di_valid2 = 1;
    tick();
    di_valid2 = 0;
    n = 0;
    while (!do_valid2 && n < 50) begin tick(); n++; end
    chk("r2_latency", 128'(n), 128'd4);
    chk("r2_pt", pt2, m_dec(128'h0, 128'h0, 128'h0, 128'h0, 2));
    chk("r2_roundtrip", m_enc(pt2, 128'h0, 128'h0, 128'h0, 2), 128'h0);

    // directed vectors on the 40-round core
    dir_v[0] = '{128'h0, 128'h0, 128'h0, 128'h0};
    dir_v[1] = '{P_CT, P_TK1, P_TK2, P_TK3};
    dir_v[2] = '{{128{1'b1}}, {128{1'b1}}, {128{1'b1}}, {128{1'b1}}};
    dir_v[3] = '{128'h00112233445566778899aabbccddeeff, 128'h0f0e0d0c0b0a09080706050403020100,
                 128'h80000000000000000000000000000001, 128'h0123456789abcdeffedcba9876543210};
    for (int v = 0; v < 4; v++) begin
      send(dir_v[v][0], dir_v[v][1], dir_v[v][2], dir_v[v][3], acc0);
      wait_idle("directed_done");
    end

    // random blocks
    for (int v = 0; v < 150; v++) begin
      send(rnd128(), rnd128(), rnd128(), rnd128(), acc0);
      wait_idle("random_done");
    end

    // back-to-back with do_ready=1
    send(rnd128(), rnd128(), rnd128(), rnd128(), acc0);
    send(rnd128(), rnd128(), rnd128(), rnd128(), acc1);
    send(rnd128(), rnd128(), rnd128(), rnd128(), acc2);
    chk("b2b_gap1", 128'(acc1 - acc0), 128'(2 * R + 2));
    chk("b2b_gap2", 128'(acc2 - acc1), 128'(2 * R + 2));
    wait_idle("b2b_done");

    // inputs toggling while busy must not disturb the captured block
    send(rnd128(), rnd128(), rnd128(), rnd128(), acc0);
    for (int k = 0; k < 2 * R - 4; k++) begin
      ct = rnd128(); key = rnd128(); cnt = rnd128(); tweak = rnd128();
      di_valid = 1'($urandom_range(0, 1));
      tick();
    end
    di_valid = 0;
    wait_idle("toggle_done");

    // backpressure for 50 cycles
    do_ready = 0;
    send(rnd128(), rnd128(), rnd128(), rnd128(), acc0);
    n = 0;
    while (!do_valid && n < 300) begin tick(); n++; end
    chk_b("bp_valid_seen", do_valid, 1'b1);
    hold = pt;
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("bp_pt_stable", pt, hold);
      chk_b("bp_do_valid", do_valid, 1'b1);
      chk_b("bp_di_ready", di_ready, 1'b0);
    end
    do_ready = 1;
    tick();
    chk_b("bp_release_valid", do_valid, 1'b0);
    chk_b("bp_release_ready", di_ready, 1'b1);

    // reset in the middle of decryption
    send(rnd128(), rnd128(), rnd128(), rnd128(), acc0);
    repeat (R + 5) tick();
    rst = 1;
    tick();
    rst = 0;
    chk_b("mid_rst_do_valid", do_valid, 1'b0);
    chk("mid_rst_pt", pt, 128'h0);
    chk_b("mid_rst_di_ready", di_ready, 1'b1);
    send(dir_v[3][0], dir_v[3][1], dir_v[3][2], dir_v[3][3], acc0);
    wait_idle("after_rst_done");

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
